// File: rtl/lock_key_pkg.sv
// Shared types and elaboration helpers for the locked-FSM key loader.
package lock_key_pkg;

    localparam int STATE_W = 3;

    // Loader FSM states.
    typedef enum logic [STATE_W-1:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_GAP  = 3'd2,
        S_DONE = 3'd3,
        S_FAIL = 3'd4
    } state_t;

    // Number of NVM words making up the key.
    function automatic int calc_nwords(input int key_w, input int word_w);
        return key_w / word_w;
    endfunction

    // Word index width, never narrower than one bit.
    function automatic int calc_addr_w(input int nwords);
        return (nwords <= 32'sd1) ? 32'sd1 : $clog2(nwords);
    endfunction

endpackage

// File: rtl/lock_timeout_ctr.sv
// Request timeout counter: counts wait cycles, flags the last tolerated one.
module lock_timeout_ctr #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CNT_W = (TIMEOUT <= 1) ? 1 : $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] cnt_r;

    // Wait-cycle counter; saturates at the expiry value so it can never wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (clear) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (enable && (cnt_r != CNT_LAST)) begin
            cnt_r <= cnt_r + CNT_ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign expire = (cnt_r == CNT_LAST);

endmodule

// File: rtl/locked_fsm_key_loader.sv
// Loads the locking key from NVM word by word and holds the locked FSM in
// reset until the complete key is present; retries failed reads.
module locked_fsm_key_loader
    import lock_key_pkg::*;
#(
    parameter int KEY_W     = 8,
    parameter int WORD_W    = 4,
    parameter int TIMEOUT   = 15,
    parameter int MAX_RETRY = 3,
    localparam int NWORDS   = calc_nwords(KEY_W, WORD_W),
    localparam int ADDR_W   = calc_addr_w(NWORDS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              nvm_req,
    output logic [ADDR_W-1:0] nvm_addr,
    input  logic              nvm_ack,
    input  logic              nvm_err,
    input  logic [WORD_W-1:0] nvm_data,
    output logic [KEY_W-1:0]  key_out,
    output logic              key_valid,
    output logic              fsm_hold,
    output logic              busy,
    output logic              fail
);

    localparam int RETRY_W = (MAX_RETRY <= 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(MAX_RETRY - 1);
    localparam logic [RETRY_W-1:0] RETRY_ONE  = RETRY_W'(1);
    localparam logic [ADDR_W-1:0]  IDX_LAST   = ADDR_W'(NWORDS - 1);
    localparam logic [ADDR_W-1:0]  IDX_ONE    = ADDR_W'(1);

    generate
        if ((KEY_W % WORD_W) != 0) begin : g_bad_key_w
            $error("KEY_W must be a multiple of WORD_W");
        end
        if ((TIMEOUT < 1) || (MAX_RETRY < 1)) begin : g_bad_limits
            $error("TIMEOUT and MAX_RETRY must be at least 1");
        end
    endgenerate

    state_t               state_r, state_nxt;
    logic [ADDR_W-1:0]    idx_r, idx_nxt;
    logic [RETRY_W-1:0]   retry_r, retry_nxt;
    logic [KEY_W-1:0]     key_r, key_nxt;
    logic                 key_valid_r, key_valid_nxt;
    logic                 fsm_hold_r, fsm_hold_nxt;
    logic                 fail_r, fail_nxt;
    logic                 tmr_clear_s, tmr_en_s, tmr_expire_s;

    lock_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_req_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (tmr_clear_s),
        .enable (tmr_en_s),
        .expire (tmr_expire_s)
    );

    // Next-state and next-register logic for the load sequencer.
    always_comb begin
        state_nxt     = state_r;
        idx_nxt       = idx_r;
        retry_nxt     = retry_r;
        key_nxt       = key_r;
        key_valid_nxt = key_valid_r;
        fsm_hold_nxt  = fsm_hold_r;
        fail_nxt      = fail_r;
        tmr_clear_s   = 1'b1;
        tmr_en_s      = 1'b0;

        case (state_r)
            S_IDLE, S_DONE, S_FAIL: begin
                if (start) begin
                    // Fresh load: wipe any previous key before the first request.
                    state_nxt     = S_REQ;
                    idx_nxt       = {ADDR_W{1'b0}};
                    retry_nxt     = {RETRY_W{1'b0}};
                    key_nxt       = {KEY_W{1'b0}};
                    key_valid_nxt = 1'b0;
                    fsm_hold_nxt  = 1'b1;
                    fail_nxt      = 1'b0;
                end else if (state_r == S_DONE) begin
                    key_valid_nxt = 1'b1;
                    fsm_hold_nxt  = 1'b0;
                end else if (state_r == S_FAIL) begin
                    fail_nxt      = 1'b1;
                    fsm_hold_nxt  = 1'b1;
                    key_nxt       = {KEY_W{1'b0}};
                end else begin
                    fsm_hold_nxt  = 1'b1;
                end
            end
            S_REQ: begin
                if (nvm_ack && !nvm_err) begin
                    for (int i = 0; i < NWORDS; i++) begin
                        if (idx_r == ADDR_W'(i)) begin
                            key_nxt[i*WORD_W +: WORD_W] = nvm_data;
                        end else begin
                            key_nxt[i*WORD_W +: WORD_W] = key_r[i*WORD_W +: WORD_W];
                        end
                    end
                    if (idx_r == IDX_LAST) begin
                        state_nxt = S_DONE;
                    end else begin
                        idx_nxt   = idx_r + IDX_ONE;
                        state_nxt = S_GAP;
                    end
                end else if (nvm_ack || tmr_expire_s) begin
                    // Corrupt data or timeout: one more failure charged to this load.
                    retry_nxt = retry_r + RETRY_ONE;
                    if (retry_r == RETRY_LAST) begin
                        state_nxt    = S_FAIL;
                        fail_nxt     = 1'b1;
                        fsm_hold_nxt = 1'b1;
                        key_nxt      = {KEY_W{1'b0}};
                    end else begin
                        state_nxt    = S_GAP;
                    end
                end else begin
                    tmr_clear_s = 1'b0;
                    tmr_en_s    = 1'b1;
                end
            end
            S_GAP: begin
                state_nxt = S_REQ;
            end
            default: begin
                state_nxt     = S_FAIL;
                fail_nxt      = 1'b1;
                fsm_hold_nxt  = 1'b1;
                key_valid_nxt = 1'b0;
                key_nxt       = {KEY_W{1'b0}};
            end
        endcase
    end

    // State and output registers; reset parks the locked FSM in hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= S_IDLE;
            idx_r       <= {ADDR_W{1'b0}};
            retry_r     <= {RETRY_W{1'b0}};
            key_r       <= {KEY_W{1'b0}};
            key_valid_r <= 1'b0;
            fsm_hold_r  <= 1'b1;
            fail_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt;
            idx_r       <= idx_nxt;
            retry_r     <= retry_nxt;
            key_r       <= key_nxt;
            key_valid_r <= key_valid_nxt;
            fsm_hold_r  <= fsm_hold_nxt;
            fail_r      <= fail_nxt;
        end
    end

    assign nvm_req   = (state_r == S_REQ);
    assign busy      = (state_r == S_REQ) || (state_r == S_GAP);
    assign nvm_addr  = idx_r;
    assign key_out   = key_r;
    assign key_valid = key_valid_r;
    assign fsm_hold  = fsm_hold_r;
    assign fail      = fail_r;

endmodule

// File: tb/tb_locked_fsm_key_loader.sv
// Self-checking bench for locked_fsm_key_loader: a scripted NVM slave plus
// a per-attempt reference model of the load outcome and timing.
module tb_locked_fsm_key_loader;

    localparam int TIMEOUT = 15;
    localparam int MAXR    = 3;
    localparam int NW      = 2;

    typedef struct {
        int         lat;   // wait cycles before ack; >= TIMEOUT means never
        bit         err;
        logic [3:0] data;
    } att_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       nvm_req;
    logic [0:0] nvm_addr;
    logic       nvm_ack = 1'b0;
    logic       nvm_err = 1'b0;
    logic [3:0] nvm_data = 4'h0;
    logic [7:0] key_out;
    logic       key_valid, fsm_hold, busy, fail;

    int tests = 0;
    int fails = 0;

    att_t plan_q[$];
    att_t slave_q[$];
    int   addr_log[$];
    int   dur_log[$];
    int   addr_unstable = 0;
    int   exp_addr[$];
    int   exp_dur[$];
    bit         m_ok;
    logic [7:0] m_key;
    int         m_cyc;

    locked_fsm_key_loader dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .nvm_req   (nvm_req),
        .nvm_addr  (nvm_addr),
        .nvm_ack   (nvm_ack),
        .nvm_err   (nvm_err),
        .nvm_data  (nvm_data),
        .key_out   (key_out),
        .key_valid (key_valid),
        .fsm_hold  (fsm_hold),
        .busy      (busy),
        .fail      (fail)
    );

    always #5 clk = ~clk;

    // NVM slave: replays one scripted attempt per request, logs address and request length.
    att_t cur;
    int   scnt = 0;
    logic [0:0] a0;
    initial begin
        forever begin
            @(negedge clk);
            if (nvm_req === 1'b1) begin
                if (scnt == 0) begin
                    if (slave_q.size() > 0) cur = slave_q.pop_front();
                    else cur = '{lat: 0, err: 1'b0, data: 4'h0};
                    addr_log.push_back(int'(nvm_addr));
                    a0 = nvm_addr;
                end else if (nvm_addr !== a0) begin
                    addr_unstable++;
                end
                if (scnt == cur.lat) begin
                    nvm_ack = 1'b1; nvm_err = cur.err; nvm_data = cur.data;
                end else begin
                    nvm_ack = 1'b0; nvm_err = 1'b0; nvm_data = 4'($urandom);
                end
                scnt++;
            end else begin
                if (scnt > 0) dur_log.push_back(scnt);
                scnt = 0; nvm_ack = 1'b0; nvm_err = 1'b0;
            end
        end
    end

    // Reference model: walks the attempt list applying the load rules.
    task automatic model();
        int nfail = 0, w = 0, cyc = 0, dur;
        exp_addr.delete(); exp_dur.delete();
        m_ok = 1'b0; m_key = 8'h00; m_cyc = -1;
        foreach (plan_q[i]) begin
            dur = (plan_q[i].lat < TIMEOUT) ? plan_q[i].lat + 1 : TIMEOUT;
            if (i > 0) cyc += 1;          // one idle cycle between requests
            cyc += dur;
            exp_addr.push_back(w);
            exp_dur.push_back(dur);
            if (plan_q[i].lat < TIMEOUT && !plan_q[i].err) begin
                m_key[w*4 +: 4] = plan_q[i].data;
                w++;
                if (w == NW) begin
                    m_ok = 1'b1; m_cyc = cyc + 1;
                    return;
                end
            end else begin
                nfail++;
                if (nfail == MAXR) begin
                    m_ok = 1'b0; m_key = 8'h00; m_cyc = cyc;
                    return;
                end
            end
        end
    endtask

    task automatic do_load(input string nm, input bit e_ok, input logic [7:0] e_key,
                           input int e_cyc, input int mid);
        int cyc;
        bit done;
        slave_q = plan_q;
        addr_log.delete(); dur_log.delete(); addr_unstable = 0;
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        tests++;
        if ({busy, key_valid, fsm_hold, fail, key_out, nvm_addr} !== {1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0}) begin
            fails++;
            $display("FAIL %s load_entry: busy=%b kv=%b hold=%b fail=%b key=%h addr=%b want 1 0 1 0 00 0",
                     nm, busy, key_valid, fsm_hold, fail, key_out, nvm_addr);
        end
        cyc = 0; done = 1'b0;
        while (!done && cyc < e_cyc + 20) begin
            if (mid > 0 && cyc == mid) start = 1'b1;
            @(posedge clk); #1; start = 1'b0;
            cyc++;
            if (key_valid === 1'b1 || fail === 1'b1) done = 1'b1;
        end
        tests++;
        if (!done || cyc != e_cyc) begin
            fails++;
            $display("FAIL %s latency: got %0d cycles (done=%b) want %0d", nm, cyc, done, e_cyc);
        end
        tests++;
        if (e_ok) begin
            if ({key_valid, fsm_hold, fail, busy, nvm_req, key_out} !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, e_key}) begin
                fails++;
                $display("FAIL %s done_state: kv=%b hold=%b fail=%b busy=%b req=%b key=%h want 1 0 0 0 0 %h",
                         nm, key_valid, fsm_hold, fail, busy, nvm_req, key_out, e_key);
            end
        end else begin
            if ({key_valid, fsm_hold, fail, busy, nvm_req, key_out} !== {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00}) begin
                fails++;
                $display("FAIL %s fail_state: kv=%b hold=%b fail=%b busy=%b req=%b key=%h want 0 1 1 0 0 00",
                         nm, key_valid, fsm_hold, fail, busy, nvm_req, key_out);
            end
        end
        @(negedge clk); #1;
        tests++;
        if (addr_log != exp_addr || dur_log != exp_dur || addr_unstable != 0) begin
            fails++;
            $display("FAIL %s req_trace: addrs=%p durs=%p unstable=%0d want addrs=%p durs=%p unstable=0",
                     nm, addr_log, dur_log, addr_unstable, exp_addr, exp_dur);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if ({nvm_req, nvm_addr, key_out, key_valid, fsm_hold, busy, fail} !== {1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL reset_values: req=%b addr=%b key=%h kv=%b hold=%b busy=%b fail=%b want 0 0 00 0 1 0 0",
                     nvm_req, nvm_addr, key_out, key_valid, fsm_hold, busy, fail);
        end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_zero_wait();
        plan_q = '{'{0, 1'b0, 4'hA}, '{0, 1'b0, 4'h5}};
        model();
        do_load("zero_wait", 1'b1, 8'h5A, 4, 0);
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (key_out !== 8'h5A || key_valid !== 1'b1) begin
            fails++;
            $display("FAIL zero_wait_frozen: key=%h kv=%b want 5a 1", key_out, key_valid);
        end
    endtask

    task automatic test_wait_states();
        plan_q = '{'{3, 1'b0, 4'h7}, '{0, 1'b0, 4'h2}};
        model();
        do_load("wait_states", 1'b1, 8'h27, 7, 0);
    endtask

    task automatic test_timeout();
        plan_q = '{'{99, 1'b0, 4'h1}, '{99, 1'b0, 4'h2}, '{99, 1'b0, 4'h3}};
        model();
        do_load("timeout", 1'b0, 8'h00, 3 * TIMEOUT + 2, 0);
    endtask

    task automatic test_err_retry();
        plan_q = '{'{0, 1'b0, 4'h3}, '{0, 1'b1, 4'hF}, '{0, 1'b0, 4'hC}};
        model();
        do_load("err_retry", 1'b1, 8'hC3, 6, 0);
    endtask

    task automatic test_start_ignored();
        plan_q = '{'{4, 1'b0, 4'h6}, '{2, 1'b0, 4'h9}};
        model();
        do_load("mid_start", 1'b1, 8'h96, 10, 3);
    endtask

    task automatic test_back_to_back();
        // Second load starts straight from DONE; entry checks cover the key_valid drop.
        plan_q = '{'{0, 1'b0, 4'h1}, '{1, 1'b0, 4'hE}};
        model();
        do_load("restart_from_done", 1'b1, 8'hE1, 5, 0);
    endtask

    task automatic test_rst_mid_load();
        plan_q = '{'{0, 1'b0, 4'h9}, '{40, 1'b0, 4'h4}};
        slave_q = plan_q;
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if ({nvm_req, nvm_addr, key_out[3:0]} !== {1'b1, 1'b1, 4'h9}) begin
            fails++;
            $display("FAIL rst_pre: req=%b addr=%b key_lo=%h want 1 1 9", nvm_req, nvm_addr, key_out[3:0]);
        end
        #1 rst = 1'b1;
        #1;
        tests++;
        if ({nvm_req, nvm_addr, key_out, key_valid, fsm_hold, busy, fail} !== {1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL rst_async: req=%b addr=%b key=%h kv=%b hold=%b busy=%b fail=%b want 0 0 00 0 1 0 0",
                     nvm_req, nvm_addr, key_out, key_valid, fsm_hold, busy, fail);
        end
        @(negedge clk); rst = 1'b0;
        slave_q.delete();
    endtask

    task automatic test_random();
        for (int n = 0; n < 25; n++) begin
            plan_q.delete();
            for (int k = 0; k < 4; k++) begin
                att_t a;
                a.lat  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, TIMEOUT + 2)) : int'($urandom_range(0, 2));
                a.err  = ($urandom_range(0, 4) == 0);
                a.data = 4'($urandom);
                plan_q.push_back(a);
            end
            model();
            do_load($sformatf("random%0d", n), m_ok, m_key, m_cyc, 0);
        end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_timeout();
        test_err_retry();
        test_start_ignored();
        test_back_to_back();
        test_rst_mid_load();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
